io_responder: RTL and testbench

Memory-mapped peripheral responder on the processor data bus. It services every load and store that the address decoder routes away from data RAM, meaning byte addresses of 1024 and above. It holds the LED output register, a synchronized switch input and a down-counting timer with an interrupt. It answers each access with a one-cycle `ready` pulse, two cycles after the request.

---
 rtl/io_responder.sv | 120 ++++++++++++
 tb/tb_io_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/io_responder.sv
// io_responder: memory-mapped peripheral responder (LED register, synchronized switches, down-counting timer)
// Parameters: BASE_ADDR byte address of offset 0x00, SW_WIDTH switch width, LED_WIDTH LED width.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   sel, req, we        - decoder select, access request (sampled in IDLE), store/load
//   address, wdata      - byte address and store data, captured with the request
//   rdata, ready, err   - response, valid for the single cycle that ready is high
//   sw_in               - asynchronous switch pins
//   led_out             - LED register contents
//   irq                 - timer interrupt level (expired & irq_en)
module io_responder #(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int SW_WIDTH = 16,
    parameter int LED_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sel,
    input  logic                 req,
    input  logic                 we,
    input  logic [31:0]          address,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 ready,
    output logic                 err,
    input  logic [SW_WIDTH-1:0]  sw_in,
    output logic [LED_WIDTH-1:0] led_out,
    output logic                 irq
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [31:0] load_q, load_d, count_q, count_d;
    logic we_q, we_d, ready_q, ready_d, err_q, err_d;
    logic en_q, en_d, ar_q, ar_d, ie_q, ie_d, exp_q, exp_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [SW_WIDTH-1:0] sw_meta_q, sw_sync_q;
    logic [31:0] offset, rd_val;
    logic [2:0] reg_idx;
    logic capture, mapped, do_wr, wr_led, wr_load, wr_ctrl, tick, expire;
    always_comb begin
        capture = (state_q == IDLE) && req && sel;
        state_d = capture ? ACCESS : (state_q == ACCESS) ? RESP : IDLE;
        addr_d  = capture ? address : addr_q;
        we_d    = capture ? we : we_q;
        wdata_d = capture ? wdata : wdata_q;
        // Offsets below BASE_ADDR wrap to huge values and so fall out as unmapped.
        offset  = addr_q - BASE_ADDR;
        reg_idx = offset[4:2];
        mapped  = (offset <= 32'h10) && (addr_q[1:0] == 2'b00);
        rd_val  = !mapped ? 32'd0 :
                  (reg_idx == 3'd0) ? 32'(led_q) :
                  (reg_idx == 3'd1) ? 32'(sw_sync_q) :
                  (reg_idx == 3'd2) ? load_q :
                  (reg_idx == 3'd3) ? count_q :
                  {23'd0, exp_q, 5'd0, ie_q, ar_q, en_q};
        do_wr   = (state_q == ACCESS) && we_q && mapped;
        wr_led  = do_wr && (reg_idx == 3'd0);
        wr_load = do_wr && (reg_idx == 3'd2);
        wr_ctrl = do_wr && (reg_idx == 3'd4);
        ready_d = state_q == ACCESS;
        rdata_d = (state_q == ACCESS) ? rd_val : 32'd0;
        err_d   = (state_q == ACCESS) && !mapped;
        led_d   = wr_led ? wdata_q[LED_WIDTH-1:0] : led_q;
        load_d  = wr_load ? wdata_q : load_q;
        en_d    = wr_ctrl ? wdata_q[0] : en_q;
        ar_d    = wr_ctrl ? wdata_q[1] : ar_q;
        ie_d    = wr_ctrl ? wdata_q[2] : ie_q;
        tick    = en_q && (count_q != 32'd0);
        expire  = tick && (count_q == 32'd1);
        // A LOAD write overrides any decrement or reload in the same cycle.
        count_d = wr_load ? wdata_q :
                  expire ? (ar_q ? load_q : 32'd0) :
                  tick ? count_q - 32'd1 : count_q;
        // A new expiry beats a simultaneous write-1-to-clear.
        exp_d   = expire || (exp_q && !(wr_ctrl && wdata_q[8]));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            led_q     <= '0;
            load_q    <= '0;
            count_q   <= '0;
            en_q      <= 1'b0;
            ar_q      <= 1'b0;
            ie_q      <= 1'b0;
            exp_q     <= 1'b0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            led_q     <= led_d;
            load_q    <= load_d;
            count_q   <= count_d;
            en_q      <= en_d;
            ar_q      <= ar_d;
            ie_q      <= ie_d;
            exp_q     <= exp_d;
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
        end
    end
    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign err     = err_q;
    assign led_out = led_q;
    assign irq     = exp_q & ie_q;
endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: self-checking bench for io_responder with directed and randomized accesses
// against a register-level model; timer values are predicted arithmetically from elapsed edges.
module tb_io_responder;
    logic        clk = 1'b0, rst = 1'b0, sel = 1'b0, req = 1'b0, we = 1'b0;
    logic [31:0] address = 32'd0, wdata = 32'd0, rdata;
    logic        ready, err, irq;
    logic [15:0] sw_in = 16'd0, led_out;
    int n_tests = 0, n_fail = 0, cyc = 0;
    int lat, wr_edge, t0, k, l_val;
    logic [31:0] r, d;
    logic        e, i_r, ar;
    logic [15:0] m_led, m_sw;
    logic [31:0] m_load, m_count;
    logic [2:0]  m_ctrl;

    io_responder dut (
        .clk(clk), .rst(rst), .sel(sel), .req(req), .we(we), .address(address),
        .wdata(wdata), .rdata(rdata), .ready(ready), .err(err), .sw_in(sw_in),
        .led_out(led_out), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus access; leaves response in r/e, irq at the response in i_r, and the
    // edge count at which the write/response happened in wr_edge.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] dat);
        @(posedge clk); #1;
        req = 1'b1; sel = 1'b1; we = w; address = a; wdata = dat;
        @(posedge clk); #1;
        req = 1'b0; sel = 1'b0; we = 1'b0; lat = 1;
        while (ready !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        r = rdata; e = err; i_r = irq; wr_edge = cyc;
        chk("latency", lat, 2);
        @(posedge clk); #1;
        chk("idle_response", {29'd0, ready, err, |rdata}, 32'd0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        access(1'b0, a, 32'd0);
        chk(tag, r, exp);
        chk({tag, "_err"}, e, 0);
    endtask

    function automatic logic [31:0] exp_cnt(int kk, int l, logic autor);
        if (autor) return 32'(l - (kk % l));
        return (kk >= l) ? 32'd0 : 32'(l - kk);
    endfunction

    function automatic logic [31:0] mread(int off);
        case (off)
            0: return 32'(m_led);
            4: return 32'(m_sw);
            8: return m_load;
            12: return m_count;
            default: return 32'(m_ctrl);
        endcase
    endfunction

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_outputs", {led_out, 12'd0, irq, ready, err, |rdata}, 32'd0);
        #20 rst = 1'b0;
        rd(1032, 0, "rst_load");
        rd(1036, 0, "rst_count");
        rd(1040, 0, "rst_ctrl");

        access(1'b1, 1024, 32'h0000_A5A5);
        chk("led_store_err", e, 0);
        chk("led_out", led_out, 32'hA5A5);
        rd(1024, 32'h0000_A5A5, "led_read");

        sw_in = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        rd(1028, 32'h0000_1234, "sw_read");
        access(1'b1, 1028, 32'hFFFF_FFFF);
        chk("ro_store_err", e, 0);
        rd(1028, 32'h0000_1234, "sw_unchanged");

        access(1'b0, 1030, 0);
        chk("misaligned", {r[30:0], e}, 32'd1);
        access(1'b0, 1044, 0);
        chk("unmapped_ld", {r[30:0], e}, 32'd1);
        access(1'b1, 1044, 32'hDEAD_BEEF);
        chk("unmapped_st_err", e, 1);
        rd(1024, 32'h0000_A5A5, "led_after_unmapped");
        rd(1032, 0, "load_after_unmapped");
        rd(1040, 0, "ctrl_after_unmapped");

        // One-shot timer: LOAD=3, enable with irq_en.
        access(1'b1, 1032, 3);
        rd(1036, 3, "count_loaded");
        access(1'b1, 1040, 32'h5);
        t0 = wr_edge;
        for (int j = 0; j < 4; j++) begin
            chk("irq_oneshot", irq, 32'((cyc - t0) >= 3));
            @(posedge clk); #1;
        end
        rd(1036, 0, "count_held_zero");
        rd(1040, 32'h105, "ctrl_expired");
        access(1'b1, 1040, 32'h105);
        chk("w1c_irq", {i_r, irq}, 0);
        rd(1040, 32'h5, "ctrl_cleared");

        // Autoreload with LOAD=2: period of 2 edges, expiry on even edge counts.
        access(1'b1, 1040, 32'h100);
        access(1'b1, 1032, 2);
        access(1'b1, 1040, 32'h107);
        t0 = wr_edge;
        for (int j = 0; j < 3; j++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            access(1'b0, 1036, 0);
            chk("ar_count", r, exp_cnt(wr_edge - 1 - t0, 2, 1'b1));
        end
        if (((cyc + 3 - t0) % 2) == 0) begin @(posedge clk); #1; end
        access(1'b1, 1040, 32'h107);
        chk("w1c_quiet_edge", i_r, 32'(((wr_edge - t0) % 2) == 0));
        if (((cyc + 3 - t0) % 2) != 0) begin @(posedge clk); #1; end
        access(1'b1, 1040, 32'h107);
        chk("w1c_vs_expiry", i_r, 32'(((wr_edge - t0) % 2) == 0));

        // Randomized register traffic with the timer disabled.
        access(1'b1, 1040, 32'h100);
        d = $urandom;
        access(1'b1, 1032, d);
        m_load = d; m_count = d; m_ctrl = 3'd0; m_led = 16'h5A5A ^ 16'h5A5A ^ 16'hA5A5; m_sw = sw_in;
        for (int it = 0; it < 30; it++) begin
            d = $urandom;
            case ($urandom_range(0, 6))
                0: begin access(1'b1, 1024, d); chk("rnd_led_err", e, 0); m_led = d[15:0]; chk("rnd_led_out", led_out, 32'(m_led)); end
                1: begin access(1'b1, 1032, d); chk("rnd_load_err", e, 0); m_load = d; m_count = d; end
                2: begin access(1'b1, 1040, d & 32'hFFFF_FFFE); chk("rnd_ctrl_err", e, 0); m_ctrl = {d[2], d[1], 1'b0}; end
                3: begin sw_in = d[15:0]; m_sw = d[15:0]; repeat (2) @(posedge clk); #1; rd(1028, 32'(m_sw), "rnd_sw"); end
                4: begin k = 4 * $urandom_range(0, 4); rd(1024 + k, mread(k), "rnd_read"); end
                5: begin
                    k = ($urandom_range(0, 1) == 1) ? 4 * $urandom_range(0, 4) + $urandom_range(1, 3) : 4 * $urandom_range(5, 200);
                    access(d[31], 1024 + k, d);
                    chk("rnd_unmapped", {r[30:0], e}, 32'd1);
                end
                default: begin access(1'b1, (d[0] ? 1028 : 1036), d); chk("rnd_ro_err", e, 0); end
            endcase
            chk("rnd_irq", irq, 0);
        end
        for (int off = 0; off <= 16; off += 4) rd(1024 + off, mread(off), "rnd_final");

        // Randomized timer runs checked against elapsed-edge arithmetic.
        for (int it = 0; it < 5; it++) begin
            l_val = $urandom_range(1, 10);
            ar = 1'($urandom_range(0, 1));
            access(1'b1, 1040, 32'h100);
            access(1'b1, 1032, l_val);
            access(1'b1, 1040, 32'h105 | (32'(ar) << 1));
            t0 = wr_edge;
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #1;
            access(1'b0, 1036, 0);
            chk("tmr_count", r, exp_cnt(wr_edge - 1 - t0, l_val, ar));
            access(1'b0, 1040, 0);
            k = wr_edge - 1 - t0;
            chk("tmr_ctrl", r, 32'h5 | (32'(ar) << 1) | (32'(k >= l_val) << 8));
            chk("tmr_irq", i_r, 32'((wr_edge - t0) >= l_val));
        end

        // Reset during ACCESS of a LED store.
        @(posedge clk); #1;
        req = 1'b1; sel = 1'b1; we = 1'b1; address = 1024; wdata = 32'h0000_FFFF;
        @(posedge clk); #1;
        req = 1'b0; sel = 1'b0; we = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {led_out, 12'd0, irq, ready, err, |rdata}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("midrst_no_ready", ready, 0);
            @(posedge clk); #1;
        end
        chk("midrst_led", led_out, 0);
        access(1'b1, 1024, 32'h0000_5A5A);
        chk("post_rst_err", e, 0);
        chk("post_rst_led", led_out, 32'h5A5A);
        rd(1024, 32'h0000_5A5A, "post_rst_read");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
